add_sub_iter: RTL and testbench

ADD_SUB_ITER -- requirements
Module: add_sub_iter

---
 rtl/add_sub_iter_pkg.sv | 24 ++
 rtl/add_sub_iter_add_chunk.sv | 34 +++
 rtl/add_sub_iter.sv | 176 +++++++++++++++++
 tb/tb_add_sub_iter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_iter_pkg.sv
// Shared execute package for the iterative add/sub/logic unit.
// Holds the operation encodings, the FSM state encoding and the bit
// positions of the ZF/SF/OF flags inside the cf/cc vectors.
package add_sub_iter_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Flag bit indices inside cf and cc.
    localparam int F_ZF = 0;
    localparam int F_SF = 1;
    localparam int F_OF = 2;

endpackage

// File: rtl/add_sub_iter_add_chunk.sv
// add_chunk: CHUNK-bit ripple-carry adder slice.
// Ports:
//   a, b   : CHUNK-bit addends
//   cin    : carry into bit 0
//   sum    : CHUNK-bit sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow detection)
module add_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        logic c;
        sum   = '0;
        c_msb = 1'b0;
        c     = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/add_sub_iter.sv
// add_sub_iter: iterative add / sub / and / xor unit processing CHUNK bits
// per cycle, least-significant slice first, through a single reused
// add_chunk slice.
//
// Handshake: a request transfers on a rising edge where in_valid and
// in_ready are both 1; a result transfers on a rising edge where out_valid
// and out_ready are both 1. in_ready is high only in IDLE and out_valid only
// in DONE; out/cf stay stable while out_valid waits for out_ready.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid/ready  : request handshake
//   op, a, b        : operation (add/sub/and/xor) and WIDTH-bit operands
//   set_cc          : load cc with this result's flags on completion
//   out_valid/ready : result handshake
//   out             : WIDTH-bit result
//   cf              : flags of the current result {OF, SF, ZF}
//   cc              : persistent condition-code register
//   dbg_state       : current FSM state for observation
module add_sub_iter
    import add_sub_iter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       cf,
    output logic [2:0]       cc,
    output state_t           dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Index counts 0..NCHUNK: NCHUNK slice cycles plus one finalize cycle.
    localparam int IDX_W  = $clog2(NCHUNK + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0] FIN_IDX  = IDX_W'(NCHUNK);

    state_t           state;
    op_t              op_r;
    logic             set_cc_r;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             of_r;
    logic [IDX_W-1:0] idx;

    logic [CHUNK-1:0] add_sum;
    logic             add_cout;
    logic             add_cmsb;
    logic [CHUNK-1:0] chunk_res;
    logic [WIDTH-1:0] chunk_ext;
    logic [WIDTH-1:0] acc_next;
    logic [2:0]       fin_flags;
    logic             is_arith;

    assign dbg_state = state;
    assign is_arith  = (op_r == OP_ADD) || (op_r == OP_SUB);

    // Operands are shifted right each cycle, so the active slice is always
    // the low CHUNK bits.
    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .a     (opa[CHUNK-1:0]),
        .b     (opb[CHUNK-1:0]),
        .cin   (carry),
        .sum   (add_sum),
        .cout  (add_cout),
        .c_msb (add_cmsb)
    );

    always_comb begin
        chunk_res = add_sum;
        case (op_r)
            OP_AND:  chunk_res = opa[CHUNK-1:0] & opb[CHUNK-1:0];
            OP_XOR:  chunk_res = opa[CHUNK-1:0] ^ opb[CHUNK-1:0];
            default: chunk_res = add_sum;
        endcase
    end

    // New slice enters at the top of the accumulator; after NCHUNK cycles
    // the slices sit in their natural positions.
    always_comb begin
        chunk_ext                = '0;
        chunk_ext[CHUNK-1:0]     = chunk_res;
        acc_next = (acc >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));
    end

    always_comb begin
        fin_flags       = 3'b000;
        fin_flags[F_ZF] = (acc == '0);
        fin_flags[F_SF] = acc[WIDTH-1];
        fin_flags[F_OF] = of_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_r      <= OP_ADD;
            set_cc_r  <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            of_r      <= 1'b0;
            idx       <= '0;
            out       <= '0;
            cf        <= 3'b000;
            cc        <= 3'b000;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // in_ready comes up on the first edge spent in IDLE.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        op_r     <= op_t'(op);
                        set_cc_r <= set_cc;
                        opa      <= a;
                        // Subtract is a + ~b + 1: invert b here, +1 via carry.
                        opb      <= (op_t'(op) == OP_SUB) ? ~b : b;
                        carry    <= (op_t'(op) == OP_SUB);
                        acc      <= '0;
                        of_r     <= 1'b0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (idx != FIN_IDX) begin
                        acc   <= acc_next;
                        opa   <= opa >> CHUNK;
                        opb   <= opb >> CHUNK;
                        carry <= add_cout;
                        if (idx == LAST_IDX) begin
                            of_r <= is_arith & (add_cmsb ^ add_cout);
                        end
                        idx <= idx + IDX_W'(1);
                    end else begin
                        out       <= acc;
                        cf        <= fin_flags;
                        if (set_cc_r) begin
                            cc <= fin_flags;
                        end
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_iter.sv
module tb_add_sub_iter;
    import add_sub_iter_pkg::*;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         set_cc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [2:0]   cf;
    logic [2:0]   cc;
    state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]   cc_model = 3'b000;
    logic [W+2:0] exp_q[$];

    add_sub_iter #(.WIDTH(64), .CHUNK(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .set_cc    (set_cc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cf        (cf),
        .cc        (cc),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic and the signed-overflow rule.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [2:0] f);
        logic ovf;
        ovf = 1'b0;
        case (o)
            2'b00: begin r = x + y; ovf = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]); end
            2'b01: begin r = x - y; ovf = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]); end
            2'b10: r = x & y;
            default: r = x ^ y;
        endcase
        f = {ovf, r[W-1], (r == '0)};
    endfunction

    task automatic drive_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic sc, input int hold);
        logic [W-1:0] r;
        logic [2:0]   f;
        logic [W+2:0] e;
        int           lat;
        int           waitc;
        model(o, x, y, r, f);
        exp_q.push_back({f, r});
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; set_cc = sc;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk);
        #1;
        // Scribble on the inputs while the operation runs.
        in_valid = 1'b0;
        op = 2'($urandom_range(0, 3));
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        set_cc = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd5);
        e = exp_q.pop_front();
        if (!out_valid) return;
        if (sc) cc_model = e[W+2:W];
        check("out", out, e[W-1:0]);
        check("cf", 64'(cf), 64'(e[W+2:W]));
        check("cc", 64'(cc), 64'(cc_model));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            check("hold_out", out, e[W-1:0]);
            check("hold_cf", 64'(cf), 64'(e[W+2:W]));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'(W'($urandom_range(0, 3)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
        set_cc = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out, 64'd0);
        check("rst_cf", 64'(cf), 64'd0);
        check("rst_cc", 64'(cc), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_in_ready", 64'(in_ready), 64'd1);

        // Directed corner cases
        drive_op(2'b00, 64'd5, 64'd7, 1'b1, 0);
        drive_op(2'b01, 64'd3, 64'd3, 1'b0, 0);
        drive_op(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 0);
        drive_op(2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 10);
        drive_op(2'b10, 64'hF0F0_0000_1234_FFFF, 64'hFF00_FFFF_0000_8001, 1'b1, 2);
        drive_op(2'b11, 64'hFF, 64'hFF, 1'b1, 0);

        // Random traffic
        for (int n = 0; n < 24; n++) begin
            drive_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Reset in the middle of an operation: make cc nonzero first.
        drive_op(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 0);
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 64'd5; b = 64'd7; set_cc = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out", out, 64'd0);
        check("midrst_cf", 64'(cf), 64'd0);
        check("midrst_cc", 64'(cc), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        cc_model = 3'b000;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        drive_op(2'b01, 64'd10, 64'd20, 1'b0, 1);
        drive_op(2'b00, 64'd5, 64'd7, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
